// File: rtl/iq_pkg.sv
// Shared types and constants for the issue-queue wakeup/select scheduler.
package iq_pkg;

    localparam int IQ_DEPTH  = 16;
    localparam int IQ_IDX_W  = 4;
    localparam int PRF_WIDTH = 6;
    localparam int DISP_W    = 4;
    localparam int ISSUE_W   = 2;
    localparam int LANE_W    = 2;             // dispatch lane index width
    localparam int CNT_W     = 5;             // occupancy 0..IQ_DEPTH
    localparam int WK_N      = ISSUE_W + 1;   // wakeup tags per cycle: issue ports + external

    typedef logic [PRF_WIDTH-1:0] prf_tag_t;

    // Per-entry scheduling state; payload lives in the CIQ proper.
    typedef struct packed {
        logic     valid;
        prf_tag_t tag1;
        logic     rdy1;
        prf_tag_t tag2;
        logic     rdy2;
        prf_tag_t prd;
        logic     prd_v;
    } iq_entry_t;

    // CAM compare of one source tag against every broadcast this cycle.
    function automatic logic tag_hit(input prf_tag_t tag,
                                     input logic [WK_N-1:0] wk_v,
                                     input prf_tag_t [WK_N-1:0] wk_tag);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WK_N; w++)
            hit = hit | (wk_v[w] & (wk_tag[w] == tag));
        return hit;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [DISP_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < DISP_W; i++)
            c = c + CNT_W'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/iq_age_matrix.sv
// Age matrix for the issue queue: older_q[i][j]=1 means entry i is older than
// entry j. Provides the oldest requester and the oldest requester after that one.
module iq_age_matrix
    import iq_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [DISP_W-1:0]                  alloc_v,
    input  logic [DISP_W-1:0][IQ_IDX_W-1:0]    alloc_idx,
    input  logic [IQ_DEPTH-1:0]                survive,
    input  logic [IQ_DEPTH-1:0]                req,
    output logic [IQ_DEPTH-1:0]                oldest,
    output logic [IQ_DEPTH-1:0]                second
);

    logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] older_q, older_d;
    logic [IQ_DEPTH-1:0]               wr;
    logic [IQ_DEPTH-1:0][LANE_W-1:0]   wr_lane;

    // One-hot of the requester that no other requester is older than.
    function automatic logic [IQ_DEPTH-1:0] pick_oldest(
        input logic [IQ_DEPTH-1:0]                m,
        input logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0]  age);
        logic [IQ_DEPTH-1:0] g;
        logic                blk;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            blk = 1'b0;
            for (int j = 0; j < IQ_DEPTH; j++)
                blk = blk | (m[j] & age[j][i]);
            g[i] = m[i] & ~blk;
        end
        return g;
    endfunction

    assign oldest = pick_oldest(req, older_q);
    assign second = pick_oldest(req & ~oldest, older_q);

    // Entries written this cycle and the lane that wrote them (higher lane wins).
    always_comb begin
        wr      = '0;
        wr_lane = '0;
        for (int k = 0; k < DISP_W; k++) begin
            if (alloc_v[k]) begin
                wr[alloc_idx[k]]      = 1'b1;
                wr_lane[alloc_idx[k]] = LANE_W'(k);
            end
        end
    end

    // New entries are younger than every survivor; among new entries lane 0 is oldest.
    always_comb begin
        older_d = older_q;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            for (int j = 0; j < IQ_DEPTH; j++) begin
                if (wr[i] && wr[j])
                    older_d[i][j] = (wr_lane[i] < wr_lane[j]);
                else if (wr[i])
                    older_d[i][j] = 1'b0;
                else if (wr[j])
                    older_d[i][j] = survive[i];
            end
        end
    end

    // Matrix register; flush forgets all ordering.
    always_ff @(posedge clk) begin
        if (rst || flush)
            older_q <= '0;
        else
            older_q <= older_d;
    end

endmodule

// File: rtl/iq_issue_select.sv
// Wakeup/select scheduler for the centralized issue queue: tracks source
// readiness, wakes on tag broadcast and grants up to two oldest ready entries.
module iq_issue_select
    import iq_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [DISP_W-1:0]                  alloc_v,
    input  logic [DISP_W-1:0][IQ_IDX_W-1:0]    alloc_idx,
    input  logic [DISP_W-1:0][PRF_WIDTH-1:0]   alloc_prs1,
    input  logic [DISP_W-1:0]                  alloc_prs1_v,
    input  logic [DISP_W-1:0]                  alloc_prs1_rdy,
    input  logic [DISP_W-1:0][PRF_WIDTH-1:0]   alloc_prs2,
    input  logic [DISP_W-1:0]                  alloc_prs2_v,
    input  logic [DISP_W-1:0]                  alloc_prs2_rdy,
    input  logic [DISP_W-1:0][PRF_WIDTH-1:0]   alloc_prd,
    input  logic [DISP_W-1:0]                  alloc_prd_v,
    input  logic                               ext_wk_v,
    input  logic [PRF_WIDTH-1:0]               ext_wk_tag,
    input  logic [ISSUE_W-1:0]                 fu_rdy,
    output logic [ISSUE_W-1:0]                 iss_v,
    output logic [ISSUE_W-1:0][IQ_IDX_W-1:0]   iss_idx,
    output logic [ISSUE_W-1:0][PRF_WIDTH-1:0]  iss_prd,
    output logic [ISSUE_W-1:0]                 iss_prd_v,
    output logic [IQ_DEPTH-1:0]                free_mask,
    output logic [CNT_W-1:0]                   iq_count
);

    iq_entry_t [IQ_DEPTH-1:0]         ent_q, ent_d;
    logic [IQ_DEPTH-1:0]              valid_q, req, survive, issued, oldest, second, free_d;
    logic [ISSUE_W-1:0][IQ_DEPTH-1:0] gnt;
    logic [DISP_W-1:0]                alloc_en;
    logic [WK_N-1:0]                  wk_v;
    prf_tag_t [WK_N-1:0]              wk_tag;
    logic [CNT_W-1:0]                 cnt_d;
    logic                             kill;

    assign kill     = rst | flush;
    assign alloc_en = alloc_v & {DISP_W{~kill}};
    assign issued   = gnt[0] | gnt[1];
    assign survive  = valid_q & ~issued;

    // An entry requests issue once valid with both sources ready.
    always_comb begin
        valid_q = '0;
        req     = '0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            valid_q[i] = ent_q[i].valid;
            req[i]     = ent_q[i].valid & ent_q[i].rdy1 & ent_q[i].rdy2;
        end
    end

    iq_age_matrix u_age (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .alloc_v   (alloc_en),
        .alloc_idx (alloc_idx),
        .survive   (survive),
        .req       (req),
        .oldest    (oldest),
        .second    (second)
    );

    // Port 1 takes the runner-up only when port 0 is actually granting.
    always_comb begin
        gnt = '0;
        if (!kill) begin
            if (fu_rdy[0]) gnt[0] = oldest;
            if (fu_rdy[1]) gnt[1] = fu_rdy[0] ? second : oldest;
        end
    end

    // Encode grants and read out the destination tag of each issued entry.
    always_comb begin
        iss_v     = '0;
        iss_idx   = '0;
        iss_prd   = '0;
        iss_prd_v = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            iss_v[p] = |gnt[p];
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (gnt[p][i]) begin
                    iss_idx[p]   = IQ_IDX_W'(i);
                    iss_prd[p]   = ent_q[i].prd;
                    iss_prd_v[p] = ent_q[i].prd_v;
                end
            end
        end
    end

    // Broadcast set: issuing destinations (back-to-back wakeup) plus the external tag.
    always_comb begin
        wk_v   = '0;
        wk_tag = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            wk_v[p]   = iss_v[p] & iss_prd_v[p];
            wk_tag[p] = iss_prd[p];
        end
        wk_v[ISSUE_W]   = ext_wk_v;
        wk_tag[ISSUE_W] = ext_wk_tag;
    end

    // Next entry state: wake, retire issued, then write allocations (higher lane wins).
    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (ent_q[i].valid) begin
                ent_d[i].rdy1 = ent_q[i].rdy1 | tag_hit(ent_q[i].tag1, wk_v, wk_tag);
                ent_d[i].rdy2 = ent_q[i].rdy2 | tag_hit(ent_q[i].tag2, wk_v, wk_tag);
            end
            if (issued[i])
                ent_d[i].valid = 1'b0;
        end
        for (int k = 0; k < DISP_W; k++) begin
            if (alloc_en[k]) begin
                ent_d[alloc_idx[k]] = '{
                    valid: 1'b1,
                    tag1:  alloc_prs1[k],
                    rdy1:  ~alloc_prs1_v[k] | alloc_prs1_rdy[k] | tag_hit(alloc_prs1[k], wk_v, wk_tag),
                    tag2:  alloc_prs2[k],
                    rdy2:  ~alloc_prs2_v[k] | alloc_prs2_rdy[k] | tag_hit(alloc_prs2[k], wk_v, wk_tag),
                    prd:   alloc_prd[k],
                    prd_v: alloc_prd_v[k]
                };
            end
        end
    end

    // Free mask and occupancy follow the committed entry state.
    always_comb begin
        free_d = '0;
        for (int i = 0; i < IQ_DEPTH; i++)
            free_d[i] = ~ent_d[i].valid;
        cnt_d = iq_count + popcount(alloc_en) - popcount(DISP_W'(iss_v));
    end

    // State registers; flush has the same effect as reset.
    always_ff @(posedge clk) begin
        if (kill) begin
            ent_q     <= '0;
            free_mask <= '1;
            iq_count  <= '0;
        end else begin
            ent_q     <= ent_d;
            free_mask <= free_d;
            iq_count  <= cnt_d;
        end
    end

    // Dispatch must target free entries with distinct indices.
    always_ff @(posedge clk) begin
        if (!kill) begin
            for (int k = 0; k < DISP_W; k++) begin
                if (alloc_v[k])
                    assert (!ent_q[alloc_idx[k]].valid);
                for (int m = k + 1; m < DISP_W; m++)
                    assert (!(alloc_v[k] && alloc_v[m] && (alloc_idx[k] == alloc_idx[m])));
            end
        end
    end

endmodule

// File: tb/tb_iq_issue_select.sv
// Bench for iq_issue_select: directed scenarios then random traffic, checked
// against an age-by-sequence-number model of the queue.
module tb_iq_issue_select;
    import iq_pkg::*;

    logic clk = 1'b0;
    logic rst, flush;
    logic [3:0]      alloc_v;
    logic [3:0][3:0] alloc_idx;
    logic [3:0][5:0] alloc_prs1, alloc_prs2, alloc_prd;
    logic [3:0]      alloc_prs1_v, alloc_prs1_rdy, alloc_prs2_v, alloc_prs2_rdy, alloc_prd_v;
    logic            ext_wk_v;
    logic [5:0]      ext_wk_tag;
    logic [1:0]      fu_rdy;
    logic [1:0]      iss_v, iss_prd_v;
    logic [1:0][3:0] iss_idx;
    logic [1:0][5:0] iss_prd;
    logic [15:0]     free_mask;
    logic [4:0]      iq_count;

    always #5 clk = ~clk;

    iq_issue_select dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_v(alloc_v), .alloc_idx(alloc_idx),
        .alloc_prs1(alloc_prs1), .alloc_prs1_v(alloc_prs1_v), .alloc_prs1_rdy(alloc_prs1_rdy),
        .alloc_prs2(alloc_prs2), .alloc_prs2_v(alloc_prs2_v), .alloc_prs2_rdy(alloc_prs2_rdy),
        .alloc_prd(alloc_prd), .alloc_prd_v(alloc_prd_v),
        .ext_wk_v(ext_wk_v), .ext_wk_tag(ext_wk_tag), .fu_rdy(fu_rdy),
        .iss_v(iss_v), .iss_idx(iss_idx), .iss_prd(iss_prd), .iss_prd_v(iss_prd_v),
        .free_mask(free_mask), .iq_count(iq_count)
    );

    int tests = 0;
    int fails = 0;

    // Model: age is a global allocation sequence number, smaller = older.
    bit         m_valid [16];
    logic [5:0] m_t1 [16], m_t2 [16], m_prd [16];
    bit         m_r1 [16], m_r2 [16], m_prdv [16];
    int         m_seq [16];
    int         seq_ctr = 0;
    int         m_count = 0;
    int         e [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oldest_of(input bit [15:0] mask);
        int best = -1;
        for (int i = 0; i < 16; i++)
            if (mask[i] && (best < 0 || m_seq[i] < m_seq[best])) best = i;
        return best;
    endfunction

    task automatic predict();
        bit [15:0] rq = '0;
        for (int i = 0; i < 16; i++) rq[i] = m_valid[i] && m_r1[i] && m_r2[i];
        e[0] = -1;
        e[1] = -1;
        if (!(rst || flush)) begin
            if (fu_rdy[0]) e[0] = oldest_of(rq);
            if (fu_rdy[1]) begin
                if (e[0] >= 0) rq[e[0]] = 1'b0;
                e[1] = oldest_of(rq);
            end
        end
    endtask

    task automatic check_outputs();
        bit [15:0] fm;
        for (int i = 0; i < 16; i++) fm[i] = !m_valid[i];
        chk("free_mask", 32'(free_mask), 32'(fm));
        chk("iq_count", 32'(iq_count), 32'(m_count));
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("iss_v%0d", p), 32'(iss_v[p]), 32'(e[p] >= 0));
            if (e[p] >= 0) begin
                chk($sformatf("iss_idx%0d", p), 32'(iss_idx[p]), 32'(e[p]));
                chk($sformatf("iss_prd%0d", p), 32'(iss_prd[p]), 32'(m_prd[e[p]]));
                chk($sformatf("iss_prd_v%0d", p), 32'(iss_prd_v[p]), 32'(m_prdv[e[p]]));
            end
        end
    endtask

    function automatic bit woken(input logic [5:0] t, input logic [5:0] wt[$]);
        foreach (wt[w]) if (wt[w] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic update_model();
        logic [5:0] wt[$];
        int n_iss = 0;
        if (rst || flush) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            m_count = 0;
            return;
        end
        for (int p = 0; p < 2; p++)
            if (e[p] >= 0) begin
                if (m_prdv[e[p]]) wt.push_back(m_prd[e[p]]);
                m_valid[e[p]] = 1'b0;
                n_iss++;
            end
        if (ext_wk_v) wt.push_back(ext_wk_tag);
        for (int i = 0; i < 16; i++)
            if (m_valid[i]) begin
                if (woken(m_t1[i], wt)) m_r1[i] = 1'b1;
                if (woken(m_t2[i], wt)) m_r2[i] = 1'b1;
            end
        for (int k = 0; k < 4; k++)
            if (alloc_v[k]) begin
                int i = int'(alloc_idx[k]);
                m_valid[i] = 1'b1;
                m_t1[i]    = alloc_prs1[k];
                m_r1[i]    = !alloc_prs1_v[k] || alloc_prs1_rdy[k] || woken(alloc_prs1[k], wt);
                m_t2[i]    = alloc_prs2[k];
                m_r2[i]    = !alloc_prs2_v[k] || alloc_prs2_rdy[k] || woken(alloc_prs2[k], wt);
                m_prd[i]   = alloc_prd[k];
                m_prdv[i]  = alloc_prd_v[k];
                m_seq[i]   = seq_ctr++;
                m_count++;
            end
        m_count -= n_iss;
    endtask

    task automatic sample_phase();
        predict();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic commit_phase();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample_phase();
        commit_phase();
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; alloc_v = '0; alloc_idx = '0;
        alloc_prs1 = '0; alloc_prs1_v = '0; alloc_prs1_rdy = '0;
        alloc_prs2 = '0; alloc_prs2_v = '0; alloc_prs2_rdy = '0;
        alloc_prd = '0; alloc_prd_v = '0;
        ext_wk_v = 1'b0; ext_wk_tag = '0; fu_rdy = 2'b11;
    endtask

    task automatic lane(input int k, input int idx, input int p1, input bit p1v, input bit p1r,
                        input int p2, input bit p2v, input bit p2r, input int prd, input bit prdv);
        alloc_v[k] = 1'b1; alloc_idx[k] = 4'(idx);
        alloc_prs1[k] = 6'(p1); alloc_prs1_v[k] = p1v; alloc_prs1_rdy[k] = p1r;
        alloc_prs2[k] = 6'(p2); alloc_prs2_v[k] = p2v; alloc_prs2_rdy[k] = p2r;
        alloc_prd[k] = 6'(prd); alloc_prd_v[k] = prdv;
    endtask

    task automatic random_inputs(input int it);
        int fq[$];
        idle();
        rst    = (it == 200);
        flush  = ($urandom_range(0, 39) == 0);
        fu_rdy = 2'($urandom_range(0, 3));
        ext_wk_v   = 1'($urandom_range(0, 1));
        ext_wk_tag = 6'($urandom_range(0, 7));
        for (int i = 0; i < 16; i++) if (!m_valid[i]) fq.push_back(i);
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 1) == 1 && fq.size() > 0) begin
                int j = $urandom_range(0, fq.size() - 1);
                lane(k, fq[j],
                     $urandom_range(0, 7), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 7), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 7), 1'($urandom_range(0, 1)));
                fq.delete(j);
                alloc_v[k] = 1'b1;
            end else begin
                alloc_idx[k] = 4'($urandom_range(0, 15));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_t1[i] = '0; m_t2[i] = '0; m_prd[i] = '0;
            m_r1[i] = 1'b0; m_r2[i] = 1'b0; m_prdv[i] = 1'b0; m_seq[i] = 0;
        end
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Post-reset state with both ports ready.
        idle();
        sample_phase();
        chk("rst_free_mask", 32'(free_mask), 32'h0000_FFFF);
        chk("rst_iss_v", 32'(iss_v), 32'd0);
        commit_phase();

        // Four ready lanes: lane order decides age.
        lane(0, 5, 0, 0, 0, 0, 0, 0, 20, 1);
        lane(1, 2, 0, 0, 0, 0, 0, 0, 21, 1);
        lane(2, 9, 0, 0, 0, 0, 0, 0, 22, 1);
        lane(3, 0, 0, 0, 0, 0, 0, 0, 23, 1);
        cycle();
        idle();
        sample_phase();
        chk("lanes_p0", 32'(iss_idx[0]), 32'd5);
        chk("lanes_p1", 32'(iss_idx[1]), 32'd2);
        commit_phase();
        sample_phase();
        chk("lanes2_p0", 32'(iss_idx[0]), 32'd9);
        chk("lanes2_p1", 32'(iss_idx[1]), 32'd0);
        commit_phase();

        // Back-to-back dependent: B waits on A's destination tag 7.
        lane(0, 3, 0, 0, 0, 0, 0, 0, 7, 1);
        lane(1, 4, 7, 1, 0, 0, 0, 0, 30, 1);
        cycle();
        idle();
        sample_phase();
        chk("dep_a_iss_v", 32'(iss_v), 32'b01);
        commit_phase();
        sample_phase();
        chk("dep_b_idx", 32'(iss_idx[0]), 32'd4);
        commit_phase();

        // External wakeup coinciding with allocation.
        lane(0, 7, 0, 0, 0, 12, 1, 0, 31, 0);
        ext_wk_v = 1'b1;
        ext_wk_tag = 6'd12;
        cycle();
        idle();
        sample_phase();
        chk("extwk_iss", 32'(iss_v[0]), 32'd1);
        commit_phase();

        // Only port 1 available: it takes the oldest.
        lane(0, 10, 0, 0, 0, 0, 0, 0, 40, 1);
        lane(1, 11, 0, 0, 0, 0, 0, 0, 41, 1);
        cycle();
        idle();
        fu_rdy = 2'b10;
        sample_phase();
        chk("p1only_iss_v", 32'(iss_v), 32'b10);
        chk("p1only_idx", 32'(iss_idx[1]), 32'd10);
        commit_phase();
        idle();
        sample_phase();
        chk("p1only_count", 32'(iq_count), 32'd1);
        commit_phase();

        // Fill the queue, then flush with ready entries pending.
        for (int b = 0; b < 4; b++) begin
            idle();
            fu_rdy = 2'b00;
            for (int k = 0; k < 4; k++)
                lane(k, b * 4 + k, 60, 1, (b == 3), 0, 0, 0, 50 + k, 1);
            cycle();
        end
        idle();
        flush = 1'b1;
        sample_phase();
        chk("full_count", 32'(iq_count), 32'd16);
        chk("full_free", 32'(free_mask), 32'd0);
        chk("flush_no_iss", 32'(iss_v), 32'd0);
        commit_phase();
        idle();
        sample_phase();
        chk("post_flush_free", 32'(free_mask), 32'h0000_FFFF);
        chk("post_flush_count", 32'(iq_count), 32'd0);
        commit_phase();

        // Random traffic.
        for (int it = 0; it < 400; it++) begin
            random_inputs(it);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
